gate_response_misr: RTL and testbench
=====================================

# gate_response_misr

Downstream response compactor for the 22-input / 10-output combinational gate models in the simulator gate library. It accepts one 10-bit response word per handshake and folds it into a 10-bit multiple-input signature register (MISR). After a programmed number of patterns it compares the signature against an expected value and reports pass/fail. Together with the upstream pattern generator it forms the lab's BIST harness around a gate model.

## Interface
Parameters:
- `SEED`, default 10'h000: MISR value loaded at reset and on each accepted start.
- `CNT_W`, default 16: width of the pattern counter and `num_patterns`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: begin a run; sampled in IDLE and DONE only.
- `num_patterns`, input, CNT_W: patterns in the run; captured when start is accepted.
- `expected_sig`, input, 10: golden signature; sampled on the cycle the last response is accepted.
- `resp_valid`, input, 1: `resp` carries a gate-model output word.
- `resp`, input, 10: gate-model outputs. Bit order is {N522,N521,N520,N519,N518,N517,N514,N506,N500,N492}, MSB first.
- `resp_ready`, output, 1: high exactly while in RUN.
- `busy`, output, 1: high in RUN.
- `done`, output, 1: high in DONE.
- `pass`, output, 1: result of the signature compare; meaningful only while `done` is high.
- `signature`, output, 10: current MISR contents.
- `count`, output, CNT_W: responses accepted in the current run.

## Operation
- Reset values: state IDLE, `busy`=0, `done`=0, `pass`=0, `resp_ready`=0, `signature`=SEED, `count`=0.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE or DONE with `start`=1 and `num_patterns`≠0: go to RUN. Latch `num_patterns`, load `signature`=SEED, clear `count`, `pass` and `done`.
  - IDLE or DONE with `start`=1 and `num_patterns`=0: go to DONE directly. `signature`=SEED; `pass`=(SEED==`expected_sig`).
  - RUN: `start` is ignored. A response is accepted when `resp_valid && resp_ready`.
  - On each accept: update the MISR and increment `count`.
  - When the accept makes `count` equal the latched `num_patterns`: go to DONE and register `pass`=(next signature == `expected_sig`).
  - DONE: outputs hold until the next `start` or reset.
- `resp_valid` in IDLE or DONE is ignored; nothing is accepted and nothing changes.
- MISR step (Galois form, polynomial x^10+x^3+1), with s = current signature and r = resp:
  - n[0] = s[9]^r[0]
  - n[3] = s[2]^s[9]^r[3]
  - n[i] = s[i-1]^r[i] for every other i
- `count` does not wrap. The run always ends at `num_patterns`, which is at most 2^CNT_W−1.
- An asynchronous `rst` in any state, including mid-run, returns every output to its reset value immediately. The partial signature is lost.

## Timing
- Accept on edge k: `signature` and `count` show the updated values after edge k, with no extra pipeline stage.
- The last accept on edge k: `done`=1, `busy`=0, `resp_ready`=0 and a valid `pass` all appear together after edge k.
- Start accepted on edge k: `resp_ready`=1 after edge k. The first response can be accepted on edge k+1.
- Throughput is one response per cycle while `resp_valid` is held high.
- `resp_ready` is a registered state decode, with no combinational path from `resp_valid`.

## Structure
- Shared package `gate_bist_pkg` holds:
  - `RESP_W`=10
  - `MISR_TAPS`=10'h009 (feedback into bits 0 and 3)
  - the state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2
- One sub-module, `misr_core`, is combinational. It computes the next signature from (s, r) using `MISR_TAPS` and is reused by the upstream generator's self-check.
- The top level holds the FSM, the counter, the `num_patterns` latch and the `pass` register.

## Test plan
- Basic fold: reset, start with `num_patterns`=1, one response 10'h3FF, `expected_sig`=10'h3FF. Required: `signature`=10'h3FF, `done`=1 and `pass`=1 one cycle after the accept.
- Feedback tap: `num_patterns`=2, responses 10'h200 then 10'h000, `expected_sig`=10'h009. Required: `signature`=10'h200, then 10'h009; `pass`=1. Repeat with `expected_sig`=10'h008. Required: `pass`=0.
- Gapped handshake: `num_patterns`=3, with `resp_valid` toggling 1,0,1,0,1 on responses 10'h001,10'h000,10'h000. Required: `count` steps 1,2,3 on valid cycles only; final `signature`=10'h004.
- Zero-length run: `start` with `num_patterns`=0, `expected_sig`=SEED. Required: DONE one cycle later with `pass`=1 and `resp_ready` never asserted.
- Ignored inputs: `start` pulsed mid-run, and `resp_valid` driven in IDLE and DONE. Required: `count`, `signature` and state are unaffected.
- Mid-run reset: assert `rst` after 5 of 10 responses. Required: immediate return to IDLE with `signature`=SEED and `count`=0. A fresh run then completes normally.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// Shared definitions for the gate-model BIST harness:
// response width, MISR feedback taps and controller state encoding.
package gate_bist_pkg;

    localparam int RESP_W = 10;

    // Polynomial x^10 + x^3 + 1: feedback enters bits 0 and 3
    localparam logic [RESP_W-1:0] MISR_TAPS = 10'h009;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/misr_core.sv
// Combinational next-state function of the Galois-form MISR.
// Shared between the response compactor and the upstream self-check.
module misr_core
    import gate_bist_pkg::*;
(
    input  logic [RESP_W-1:0] s,
    input  logic [RESP_W-1:0] r,
    output logic [RESP_W-1:0] n
);

    logic [RESP_W-1:0] fb;

    assign fb = s[RESP_W-1] ? MISR_TAPS : '0;
    assign n  = {s[RESP_W-2:0], 1'b0} ^ fb ^ r;

endmodule

// File: rtl/gate_response_misr.sv
// Response compactor: folds gate-model outputs into a MISR and
// compares the final signature against a golden value.
module gate_response_misr
    import gate_bist_pkg::*;
#(
    parameter logic [RESP_W-1:0] SEED  = 10'h000,
    parameter int                CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_patterns,
    input  logic [RESP_W-1:0] expected_sig,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp,
    output logic              resp_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [RESP_W-1:0] signature,
    output logic [CNT_W-1:0]  count
);

    state_e            state_q;
    logic [RESP_W-1:0] sig_q;
    logic [RESP_W-1:0] sig_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  npat_q;
    logic              pass_q;
    logic              accept;

    misr_core u_misr (
        .s (sig_q),
        .r (resp),
        .n (sig_d)
    );

    assign accept = resp_valid && (state_q == RUN);
    assign cnt_d  = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            npat_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        sig_q <= SEED;
                        cnt_q <= '0;
                        if (num_patterns != '0) begin
                            npat_q  <= num_patterns;
                            pass_q  <= 1'b0;
                            state_q <= RUN;
                        end else begin
                            // Empty run: the seed itself is the signature
                            pass_q  <= (SEED == expected_sig);
                            state_q <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        sig_q <= sig_d;
                        cnt_q <= cnt_d;
                        if (cnt_d == npat_q) begin
                            pass_q  <= (sig_d == expected_sig);
                            state_q <= DONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of registered state
    assign resp_ready = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign pass       = pass_q;
    assign signature  = sig_q;
    assign count      = cnt_q;

endmodule

// File: tb/tb_gate_response_misr.sv
// Self-checking bench for gate_response_misr with a polynomial
// arithmetic reference model and randomized responses.
module tb_gate_response_misr;

    localparam logic [9:0] SEED = 10'h000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_patterns = '0;
    logic [9:0]  expected_sig = '0;
    logic        resp_valid = 1'b0;
    logic [9:0]  resp = '0;
    logic        resp_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [9:0]  signature;
    logic [15:0] count;

    int vectors = 0;
    int errors  = 0;

    logic [9:0] dq[$];

    gate_response_misr #(.SEED(SEED), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_patterns (num_patterns),
        .expected_sig (expected_sig),
        .resp_valid   (resp_valid),
        .resp         (resp),
        .resp_ready   (resp_ready),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature),
        .count        (count)
    );

    always #5 clk = ~clk;

    // Signature as a polynomial over GF(2): multiply by x mod
    // x^10+x^3+1, then add the response word.
    function automatic logic [9:0] mstep(logic [9:0] s, logic [9:0] r);
        int v;
        v = int'(s) * 2;
        if (v >= 1024) v = v ^ 'h409;
        return 10'(v) ^ r;
    endfunction

    function automatic logic [9:0] fold(logic [9:0] s0);
        logic [9:0] s;
        s = s0;
        foreach (dq[i]) s = mstep(s, dq[i]);
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_like(input string tag, input logic [9:0] sig,
                                   input logic [15:0] cnt, input logic dn,
                                   input logic ps);
        check({tag, "_sig"}, 32'(signature), 32'(sig));
        check({tag, "_cnt"}, 32'(count), 32'(cnt));
        check({tag, "_done"}, 32'(done), 32'(dn));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_rdy"}, 32'(resp_ready), 32'(0));
        if (dn) check({tag, "_pass"}, 32'(pass), 32'(ps));
    endtask

    // mode 0: valid every cycle, 1: alternate 1,0,1..., 2: random
    task automatic run(input string tag, input int mode, input bit want_pass);
        int np, acc, cyc;
        logic [9:0] s, fin, exp;
        np  = dq.size();
        fin = fold(SEED);
        exp = want_pass ? fin : fin ^ 10'(($urandom % 1023) + 1);
        num_patterns = 16'(np);
        expected_sig = exp;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_start_rdy"}, 32'(resp_ready), 32'(1));
        check({tag, "_start_busy"}, 32'(busy), 32'(1));
        check({tag, "_start_sig"}, 32'(signature), 32'(SEED));
        check({tag, "_start_cnt"}, 32'(count), 32'(0));
        s = SEED;
        acc = 0;
        cyc = 0;
        while (acc < np && cyc < 1000) begin
            case (mode)
                0: resp_valid = 1'b1;
                1: resp_valid = (cyc % 2) == 0;
                default: resp_valid = 1'($urandom);
            endcase
            resp  = resp_valid ? dq[acc] : 10'($urandom);
            start = 1'($urandom);
            num_patterns = 16'($urandom);
            tick();
            cyc++;
            if (resp_valid) begin
                s = mstep(s, dq[acc]);
                acc++;
            end
            check({tag, "_sig"}, 32'(signature), 32'(s));
            check({tag, "_cnt"}, 32'(count), 32'(acc));
            check({tag, "_done"}, 32'(done), 32'(acc == np));
            check({tag, "_busy"}, 32'(busy), 32'(acc != np));
        end
        start = 1'b0;
        resp_valid = 1'b0;
        check({tag, "_budget"}, 32'(acc), 32'(np));
        check({tag, "_fin_sig"}, 32'(signature), 32'(fin));
        check({tag, "_pass"}, 32'(pass), 32'(want_pass));
        check({tag, "_fin_rdy"}, 32'(resp_ready), 32'(0));
        // Responses presented in DONE must be ignored
        for (int i = 0; i < 3; i++) begin
            resp_valid = 1'b1;
            resp = 10'($urandom);
            tick();
        end
        resp_valid = 1'b0;
        check_idle_like({tag, "_hold"}, fin, 16'(np), 1'b1, want_pass);
    endtask

    initial begin
        int n;
        #2;
        check_idle_like("rst", SEED, 16'd0, 1'b0, 1'b0);
        check("rst_pass", 32'(pass), 32'(0));
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 3; i++) begin
            resp_valid = 1'b1;
            resp = 10'($urandom);
            tick();
        end
        resp_valid = 1'b0;
        check_idle_like("idle_ign", SEED, 16'd0, 1'b0, 1'b0);

        dq = '{10'h3FF};
        run("basic", 0, 1'b1);

        dq = '{10'h200, 10'h000};
        check("tap_model", 32'(fold(SEED)), 32'h009);
        run("tap_pass", 0, 1'b1);
        expected_sig = 10'h008;
        num_patterns = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        resp_valid = 1'b1;
        resp = 10'h200;
        tick();
        check("tap_mid_sig", 32'(signature), 32'h200);
        resp = 10'h000;
        tick();
        resp_valid = 1'b0;
        check("tap_fail_sig", 32'(signature), 32'h009);
        check("tap_fail_done", 32'(done), 32'(1));
        check("tap_fail_pass", 32'(pass), 32'(0));

        dq = '{10'h001, 10'h000, 10'h000};
        check("gap_model", 32'(fold(SEED)), 32'h004);
        run("gap", 1, 1'b1);

        num_patterns = 16'd0;
        expected_sig = SEED;
        start = 1'b1;
        #1;
        check("zero_pre_rdy", 32'(resp_ready), 32'(0));
        tick();
        start = 1'b0;
        check_idle_like("zero", SEED, 16'd0, 1'b1, 1'b1);
        expected_sig = SEED ^ 10'h155;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_idle_like("zero_bad", SEED, 16'd0, 1'b1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            n = int'($urandom_range(1, 40));
            dq.delete();
            for (int i = 0; i < n; i++) dq.push_back(10'($urandom));
            run($sformatf("rnd%0d", k), 2, k % 2 == 0);
        end

        dq.delete();
        for (int i = 0; i < 10; i++) dq.push_back(10'($urandom));
        num_patterns = 16'd10;
        expected_sig = fold(SEED);
        start = 1'b1;
        tick();
        start = 1'b0;
        resp_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            resp = dq[i];
            tick();
        end
        resp_valid = 1'b0;
        check("mr_cnt5", 32'(count), 32'(5));
        rst = 1'b1;
        #1;
        check_idle_like("mr_async", SEED, 16'd0, 1'b0, 1'b0);
        check("mr_pass", 32'(pass), 32'(0));
        tick();
        rst = 1'b0;
        tick();
        run("mr_fresh", 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
